hazard_sched_ctrl: RTL

Hazard and interlock controller for the 5-stage MIPS pipeline. It sequences the F/D and D/E pipeline registers by generating stall, flush and forwarding selects from the register fields and control bits of the D, E, M and W stages. It also owns a multi-cycle multiply/divide busy FSM, which holds the pipeline while HI/LO results are pending. A saturating stall counter is kept for performance observation.

---
 rtl/hazard_sched_ctrl_if.sv | 31 +++
 rtl/hazard_sched_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/hazard_sched_ctrl_if.sv
// Pipeline-side bundle for the hazard/interlock controller: stage register
// fields and control bits in, stall/flush/forward selects and mult/div status out.
interface hazard_sched_ctrl_if;
  logic [4:0]  RsD, RtD, RsE, RtE;
  logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW;
  logic        MemtoRegE, MemtoRegM;
  logic        BranchD, PCSrcD;
  logic        MdUseD, MdStartE, MdDivE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        ForwardAD, ForwardBD;
  logic        MdBusy, MdDone;
  logic [15:0] StallCnt;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, PCSrcD, MdUseD, MdStartE, MdDivE,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           ForwardAD, ForwardBD, MdBusy, MdDone, StallCnt
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, PCSrcD, MdUseD, MdStartE, MdDivE,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           ForwardAD, ForwardBD, MdBusy, MdDone, StallCnt
  );
endinterface

// File: rtl/hazard_sched_ctrl.sv
// Hazard/interlock controller for the 5-stage pipeline: forwarding selects,
// load-use/branch/mult-div stalls, mult/div busy FSM and a saturating stall counter.
module hazard_sched_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input logic               clk,
  input logic               rst_n,
  hazard_sched_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_t        state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             md_busy_r, md_done_r;
  logic [15:0]      stall_cnt_r;
  logic             lw_stall_s, br_stall_s, md_stall_s, stall_s;
  logic [1:0]       fwd_ae_s, fwd_be_s;
  logic             fwd_ad_s, fwd_bd_s;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  // Mult/div state register; status flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= MD_IDLE;
      cnt_r     <= '0;
      md_busy_r <= 1'b0;
      md_done_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      md_busy_r <= (state_nxt_s != MD_IDLE);
      md_done_r <= (state_nxt_s == MD_DONE);
    end
  end

  // Mult/div next-state and countdown; a start outside IDLE is ignored.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      MD_IDLE: begin
        if (hz.MdStartE) begin
          state_nxt_s = MD_BUSY;
          cnt_nxt_s   = hz.MdDivE ? DIV_LOAD : MUL_LOAD;
        end else begin
          state_nxt_s = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (cnt_r == '0) begin
          state_nxt_s = MD_DONE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      MD_DONE: state_nxt_s = MD_IDLE;
      default: begin
        state_nxt_s = MD_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Zero-latency hazard detection and forwarding selects (M beats W).
  always_comb begin
    lw_stall_s = hz.MemtoRegE && reg_hit(hz.RtE, hz.RsD)
              || hz.MemtoRegE && reg_hit(hz.RtE, hz.RtD);
    br_stall_s = hz.BranchD &&
                 ((hz.RegWriteE && (reg_hit(hz.RsD, hz.WriteRegE) || reg_hit(hz.RtD, hz.WriteRegE))) ||
                  (hz.MemtoRegM && (reg_hit(hz.RsD, hz.WriteRegM) || reg_hit(hz.RtD, hz.WriteRegM))));
    md_stall_s = hz.MdUseD && (state_r != MD_IDLE);
    stall_s    = lw_stall_s | br_stall_s | md_stall_s;

    if (hz.RegWriteM && reg_hit(hz.RsE, hz.WriteRegM)) begin
      fwd_ae_s = 2'b10;
    end else if (hz.RegWriteW && reg_hit(hz.RsE, hz.WriteRegW)) begin
      fwd_ae_s = 2'b01;
    end else begin
      fwd_ae_s = 2'b00;
    end

    if (hz.RegWriteM && reg_hit(hz.RtE, hz.WriteRegM)) begin
      fwd_be_s = 2'b10;
    end else if (hz.RegWriteW && reg_hit(hz.RtE, hz.WriteRegW)) begin
      fwd_be_s = 2'b01;
    end else begin
      fwd_be_s = 2'b00;
    end

    fwd_ad_s = hz.RegWriteM && reg_hit(hz.RsD, hz.WriteRegM);
    fwd_bd_s = hz.RegWriteM && reg_hit(hz.RtD, hz.WriteRegM);
  end

  // Performance counter of stalled cycles, held at all-ones once full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'd0;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // A taken branch is only squashed once D is actually allowed to advance.
  assign hz.StallF    = stall_s;
  assign hz.StallD    = stall_s;
  assign hz.FlushE    = stall_s;
  assign hz.FlushD    = hz.PCSrcD & ~stall_s;
  assign hz.ForwardAE = fwd_ae_s;
  assign hz.ForwardBE = fwd_be_s;
  assign hz.ForwardAD = fwd_ad_s;
  assign hz.ForwardBD = fwd_bd_s;
  assign hz.MdBusy    = md_busy_r;
  assign hz.MdDone    = md_done_r;
  assign hz.StallCnt  = stall_cnt_r;

endmodule
